// File: rtl/esn_pkg.sv
// Shared ESN definitions: heap array selects, SRAM state encodings and the
// off-chip loader FSM state type.
package esn_pkg;

    localparam logic [2:0] SEL_X    = 3'd0;
    localparam logic [2:0] SEL_W    = 3'd1;
    localparam logic [2:0] SEL_WIN  = 3'd2;
    localparam logic [2:0] SEL_WINB = 3'd3;
    localparam logic [2:0] SEL_WOUT = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_LOAD   = 2'd1,
        LD_FINISH = 2'd2
    } ld_state_e;

endpackage

// File: rtl/esn_addr_wrap.sv
// Registered heap address counter: load has priority over increment, and the
// increment wraps from node_num-1 back to 0.
module esn_addr_wrap #(
    parameter int addr_length = 10,
    parameter int node_num    = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [addr_length-1:0] load_val_i,
    input  logic                   inc_i,
    output logic [addr_length-1:0] addr_o
);

    logic [addr_length-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (inc_i) begin
            addr_d = (addr_q == addr_length'(node_num - 1)) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/esn_offchip_loader.sv
// Streams off-chip words into one ESN heap array through the heap's registered
// off-chip write port. Optional running checksum: LOADER_CHECKSUM_EN.
module esn_offchip_loader
    import esn_pkg::*;
#(
    parameter int addr_length = 10,
    parameter int bit_length  = 32,
    parameter int node_num    = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             cmd_sel,
    input  logic [addr_length-1:0] cmd_base,
    input  logic [addr_length:0]   cmd_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [bit_length-1:0]  in_data,
    output logic [1:0]             SRAM_State,
    output logic [2:0]             SEL_inSRAM_offchip,
    output logic [addr_length-1:0] addr_inSRAM_offchip,
    output logic [bit_length-1:0]  Data_offchip,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
`ifdef LOADER_CHECKSUM_EN
    output logic [bit_length-1:0]  checksum,
`endif
    output logic [1:0]             dbg_state
);

    // Stream handshake: a word transfers on every rising edge where
    // in_valid && in_ready; in_ready is registered and depends only on state.
    ld_state_e              state_q, state_d;
    logic [2:0]             sel_q;
    logic [addr_length:0]   len_q, cnt_q;
    logic [addr_length-1:0] cur_addr;
    logic                   in_ready_q, err_d, addr_load, accept, last_word;
    logic                   bad_sel, bad_range;
    logic [1:0]             sram_state_q;
    logic [2:0]             sel_out_q;
    logic [addr_length-1:0] addr_out_q;
    logic [bit_length-1:0]  data_out_q;
    logic                   done_q, err_q;

    assign accept    = in_valid & in_ready_q;
    assign last_word = accept && (cnt_q == len_q - 1'b1);
    assign bad_sel   = cmd_sel > SEL_WOUT;
    assign bad_range = (cmd_len > (addr_length + 1)'(node_num)) ||
                       (cmd_base >= addr_length'(node_num));

    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        addr_load = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    if (bad_sel) begin
                        err_d = 1'b1;
                    end else if (cmd_len == '0) begin
                        state_d = LD_FINISH;
                    end else if (bad_range) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = LD_LOAD;
                        addr_load = 1'b1;
                    end
                end
            end
            LD_LOAD: begin
                if (last_word) state_d = LD_FINISH;
            end
            LD_FINISH: state_d = LD_IDLE;
            default:   state_d = LD_IDLE;
        endcase
    end

    esn_addr_wrap #(
        .addr_length(addr_length),
        .node_num   (node_num)
    ) u_addr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (addr_load),
        .load_val_i(cmd_base),
        .inc_i     (accept),
        .addr_o    (cur_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LD_IDLE;
            sel_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            sram_state_q <= ST_IDLE;
            sel_out_q    <= '0;
            addr_out_q   <= '0;
            data_out_q   <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == LD_LOAD);
            err_q      <= err_d;
            done_q     <= (state_q == LD_FINISH);
            if (state_q == LD_IDLE && start) begin
                sel_q <= cmd_sel;
                len_q <= cmd_len;
            end
            if (addr_load) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Write-port fields only move with a fresh word; otherwise they hold.
            if (accept) begin
                sram_state_q <= ST_WRITE;
                sel_out_q    <= sel_q;
                addr_out_q   <= cur_addr;
                data_out_q   <= in_data;
            end else begin
                sram_state_q <= ST_IDLE;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [bit_length-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (state_q == LD_IDLE && start && !err_d) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + in_data;
        end
    end

    assign checksum = csum_q;
`endif

    assign in_ready            = in_ready_q;
    assign busy                = (state_q != LD_IDLE);
    assign done                = done_q;
    assign err                 = err_q;
    assign SRAM_State          = sram_state_q;
    assign SEL_inSRAM_offchip  = sel_out_q;
    assign addr_inSRAM_offchip = addr_out_q;
    assign Data_offchip        = data_out_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_esn_offchip_loader.sv
// Self-checking bench for esn_offchip_loader: randomized commands and streams
// compared with a queue-based model of the expected heap writes.
module tb_esn_offchip_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  cmd_sel = '0;
    logic [9:0]  cmd_base = '0;
    logic [10:0] cmd_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  sram_state;
    logic [2:0]  sel_o;
    logic [9:0]  addr_o;
    logic [31:0] data_o;
    logic        busy, done, err;
    logic [1:0]  dbg_state;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int nchecks = 0;
    int nfail   = 0;
    int cyc     = 0;

    esn_offchip_loader dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .cmd_sel            (cmd_sel),
        .cmd_base           (cmd_base),
        .cmd_len            (cmd_len),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .SRAM_State         (sram_state),
        .SEL_inSRAM_offchip (sel_o),
        .addr_inSRAM_offchip(addr_o),
        .Data_offchip       (data_o),
        .busy               (busy),
        .done               (done),
        .err                (err),
`ifdef LOADER_CHECKSUM_EN
        .checksum           (checksum),
`endif
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records what the heap would see on each cycle.
    logic [44:0] got_q[$];
    int          got_cyc[$];
    int          done_cycles[$];
    int          err_cycles[$];
    int          bad_state = 0;
    logic [31:0] data_src[$];
    int          last_t0, last_done;

    always @(negedge clk) begin
        if (sram_state == 2'b01) begin
            got_q.push_back({sel_o, addr_o, data_o});
            got_cyc.push_back(cyc);
        end else if (sram_state !== 2'b00) begin
            bad_state++;
        end
        if (done === 1'b1) done_cycles.push_back(cyc);
        if (err === 1'b1) err_cycles.push_back(cyc);
    end

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
        done_cycles.delete();
        err_cycles.delete();
        bad_state = 0;
    endtask

    task automatic run_cmd(input logic [2:0] sel, input logic [9:0] base, input logic [10:0] len,
                           input int pct, input logic [15:0] vpat, input bit use_pat,
                           input string name);
        logic [44:0] exp_q[$];
        int          exp_cyc[$];
        bit          exp_err;
        int          t0, accepted, last_acc, k, budget, exp_done;
        int          bad_ready, bad_busy, bad_idle, n;
        logic [9:0]  a;
        logic [31:0] d, csum;
        logic        v;
        clear_mon();
        exp_err = (sel > 3'd4) || (len != 0 && (len > 11'd1000 || base >= 10'd1000));
        @(posedge clk); #1;
        start = 1'b1; cmd_sel = sel; cmd_base = base; cmd_len = len;
        in_valid = 1'($urandom_range(1)); in_data = $urandom;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        cmd_sel = 3'($urandom); cmd_base = 10'($urandom); cmd_len = 11'($urandom);
        a = base; accepted = 0; last_acc = t0; k = 0; budget = 0; csum = '0;
        bad_ready = 0; bad_busy = 0; bad_idle = 0;
        if (!exp_err && len != 0) begin
            while (accepted < int'(len) && budget < 4000) begin
                if (in_ready !== 1'b1) bad_ready++;
                if (busy !== 1'b1) bad_busy++;
                v = use_pat ? vpat[k % 16] : ($urandom_range(99) < pct);
                k++; budget++;
                d = (v && data_src.size() > 0) ? data_src.pop_front() : $urandom;
                in_valid = v; in_data = d;
                if (v) begin
                    exp_q.push_back({sel, a, d});
                    exp_cyc.push_back(cyc + 1);
                    a = (a == 10'd999) ? 10'd0 : a + 10'd1;
                    accepted++;
                    last_acc = cyc;
                    csum = csum + d;
                end
                start = ($urandom_range(9) == 0);
                @(posedge clk); #1;
            end
            start = 1'b0;
            nchecks++;
            if (accepted !== int'(len)) begin
                nfail++;
                $display("FAIL %s timeout: accepted %0d of %0d", name, accepted, len);
            end
        end
        in_valid = 1'b1; in_data = $urandom;
        nchecks++;
        if (in_ready !== 1'b0) begin
            nfail++;
            $display("FAIL %s ready_after: in_ready=%b expected 0", name, in_ready);
        end
        exp_done = exp_err ? -1 : ((len == 0) ? t0 + 2 : last_acc + 2);
        repeat (4) begin
            if (exp_err && (busy !== 1'b0 || in_ready !== 1'b0)) bad_idle++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        while (cyc <= exp_done + 1) begin
            @(posedge clk); #1;
        end
        nchecks++;
        if (bad_ready != 0 || bad_busy != 0 || bad_idle != 0) begin
            nfail++;
            $display("FAIL %s ready_busy: bad_ready=%0d bad_busy=%0d bad_idle=%0d expected 0",
                     name, bad_ready, bad_busy, bad_idle);
        end
        nchecks++;
        if (got_q.size() != exp_q.size() || bad_state != 0) begin
            nfail++;
            $display("FAIL %s write_count: got %0d writes (bad_state %0d) expected %0d",
                     name, got_q.size(), bad_state, exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            nchecks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i]) begin
                nfail++;
                $display("FAIL %s write[%0d]: got sel/addr/data=%h at %0d expected %h at %0d",
                         name, i, got_q[i], got_cyc[i], exp_q[i], exp_cyc[i]);
            end
        end
        nchecks++;
        if (exp_err ? (done_cycles.size() != 0)
                    : (done_cycles.size() != 1 || done_cycles[0] != exp_done)) begin
            nfail++;
            $display("FAIL %s done: got %0d pulses first at %0d expected %0d at %0d", name,
                     done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] : -1,
                     exp_err ? 0 : 1, exp_done);
        end
        nchecks++;
        if (exp_err ? (err_cycles.size() != 1 || err_cycles[0] != t0 + 1)
                    : (err_cycles.size() != 0)) begin
            nfail++;
            $display("FAIL %s err: got %0d pulses expected %0d (at %0d)", name,
                     err_cycles.size(), exp_err ? 1 : 0, t0 + 1);
        end
`ifdef LOADER_CHECKSUM_EN
        if (!exp_err) begin
            nchecks++;
            if (checksum !== csum) begin
                nfail++;
                $display("FAIL %s checksum: got %h expected %h", name, checksum, csum);
            end
        end
`endif
        last_t0 = t0;
        last_done = (done_cycles.size() > 0) ? done_cycles[0] : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nchecks++;
        if ({in_ready, busy, done, err, sram_state, sel_o, addr_o, data_o, dbg_state} !== '0) begin
            nfail++;
            $display("FAIL reset_values: rdy=%b busy=%b done=%b err=%b st=%b sel=%h addr=%h data=%h fsm=%h expected all 0",
                     in_ready, busy, done, err, sram_state, sel_o, addr_o, data_o, dbg_state);
        end
`ifdef LOADER_CHECKSUM_EN
        nchecks++;
        if (checksum !== 32'h0) begin
            nfail++;
            $display("FAIL reset_checksum: got %h expected 0", checksum);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) data_src.push_back(32'hA + i);
        run_cmd(3'd1, 10'd0, 11'd4, 100, 16'hFFFF, 1'b1, "basic");
        nchecks++;
        if (last_done - last_t0 != 6) begin
            nfail++;
            $display("FAIL basic_done_latency: got %0d expected 6", last_done - last_t0);
        end
    endtask

    task automatic test_wrap();
        run_cmd(3'd0, 10'd998, 11'd4, 100, 16'hFFFF, 1'b1, "wrap");
        run_cmd(3'd4, 10'd999, 11'd1000, 100, 16'hFFFF, 1'b1, "full_array");
    endtask

    task automatic test_stall();
        run_cmd(3'd2, 10'd0, 11'd3, 0, 16'b0001_0101, 1'b1, "stall");
    endtask

    task automatic test_errors();
        run_cmd(3'd5, 10'd0, 11'd4, 100, 16'hFFFF, 1'b1, "bad_sel");
        run_cmd(3'd1, 10'd0, 11'd1001, 100, 16'hFFFF, 1'b1, "len_1001");
        run_cmd(3'd1, 10'd1000, 11'd2, 100, 16'hFFFF, 1'b1, "base_1000");
        run_cmd(3'd3, 10'd5, 11'd0, 100, 16'hFFFF, 1'b1, "len_0");
    endtask

    task automatic test_mid_reset();
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; cmd_sel = 3'd2; cmd_base = 10'd10; cmd_len = 11'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1; in_data = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        nchecks++;
        if ({in_ready, busy, done, err, sram_state, sel_o, addr_o, data_o, dbg_state} !== '0) begin
            nfail++;
            $display("FAIL mid_reset_values: rdy=%b busy=%b st=%b sel=%h addr=%h data=%h fsm=%h expected all 0",
                     in_ready, busy, sram_state, sel_o, addr_o, data_o, dbg_state);
        end
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        nchecks++;
        if (done_cycles.size() != 0 || got_q.size() != 2) begin
            nfail++;
            $display("FAIL mid_reset_trace: done pulses %0d writes %0d expected 0 and 2",
                     done_cycles.size(), got_q.size());
        end
        run_cmd(3'd2, 10'd10, 11'd5, 100, 16'hFFFF, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [2:0]  s;
            logic [9:0]  b;
            logic [10:0] l;
            s = 3'($urandom_range(5));
            b = (i % 3 == 0) ? 10'($urandom_range(1023)) : 10'($urandom_range(999));
            l = (i == 7) ? 11'd1001 : 11'($urandom_range(24));
            run_cmd(s, b, l, $urandom_range(90, 20), 16'h0, 1'b0, "random");
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        data_src.push_back(32'hFFFF_FFFF);
        data_src.push_back(32'h0000_0002);
        run_cmd(3'd1, 10'd0, 11'd2, 100, 16'hFFFF, 1'b1, "checksum_wrap");
        nchecks++;
        if (checksum !== 32'h1) begin
            nfail++;
            $display("FAIL checksum_fixed: got %h expected 00000001", checksum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_errors();
        test_mid_reset();
        test_random();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
